// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the multiplier job sequencer.
// The MULT_JOB_ZERO_BYPASS_EN build option is consumed by mult_job_sequencer.
package mult_seq_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ARM   = 2'd2,
        WAIT  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mult_seq_fifo.sv
// Small synchronous job FIFO; pushes while full and pops while empty are ignored.
// DEPTH must be a power of two so pointers wrap naturally.
module mult_seq_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == CW'(0));
    assign count  = count_r;
    assign rdata  = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Queues operand pairs and feeds them one at a time to a sequential multiplier.
// Build option MULT_JOB_ZERO_BYPASS_EN: zero-operand jobs complete without the multiplier.
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_multiplier,
    input  logic [WIDTH-1:0]   in_multiplicand,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_multiplier,
    output logic [WIDTH-1:0]   mul_multiplicand,
    input  logic [2*WIDTH-1:0] mul_product,
    input  logic               mul_done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               busy,
    output logic [CW-1:0]      count
);

    seq_state_e         state_r;
    seq_state_e         state_nxt_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic [2*WIDTH-1:0] head_s;
    logic [WIDTH-1:0]   head_a_s;
    logic [WIDTH-1:0]   head_b_s;
    logic               push_s;
    logic               pop_s;
    logic               issue_s;
    logic               capture_s;
    logic               bypass_s;
    logic               slot_free_s;
    logic               zero_job_s;
    logic               mul_start_r;
    logic [WIDTH-1:0]   mul_a_r;
    logic [WIDTH-1:0]   mul_b_r;
    logic               out_valid_r;
    logic [2*WIDTH-1:0] out_product_r;

    assign in_ready    = (fifo_count_s < CW'(DEPTH));
    assign push_s      = in_valid && in_ready;
    assign head_a_s    = head_s[2*WIDTH-1:WIDTH];
    assign head_b_s    = head_s[WIDTH-1:0];
    // The slot may be refilled in the same cycle it is drained.
    assign slot_free_s = !out_valid_r || out_ready;

`ifdef MULT_JOB_ZERO_BYPASS_EN
    assign zero_job_s = (head_a_s == WIDTH'(0)) || (head_b_s == WIDTH'(0));
`else
    assign zero_job_s = 1'b0;
`endif

    mult_seq_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({in_multiplier, in_multiplicand}),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Next-state and per-cycle control decode
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        issue_s     = 1'b0;
        capture_s   = 1'b0;
        bypass_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && slot_free_s) begin
                    pop_s = 1'b1;
                    if (zero_job_s) begin
                        bypass_s    = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        issue_s     = 1'b1;
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE:   state_nxt_s = ARM;
            // Done may still be asserted from the previous job here.
            ARM:     state_nxt_s = WAIT;
            WAIT: begin
                if (mul_done) begin
                    capture_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, multiplier-side and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            mul_start_r   <= 1'b0;
            mul_a_r       <= '0;
            mul_b_r       <= '0;
            out_valid_r   <= 1'b0;
            out_product_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            mul_start_r <= issue_s;
            if (issue_s) begin
                mul_a_r <= head_a_s;
                mul_b_r <= head_b_s;
            end
            if (capture_s) begin
                out_product_r <= mul_product;
                out_valid_r   <= 1'b1;
            end else if (bypass_s) begin
                out_product_r <= '0;
                out_valid_r   <= 1'b1;
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign mul_start        = mul_start_r;
    assign mul_multiplier   = mul_a_r;
    assign mul_multiplicand = mul_b_r;
    assign out_valid        = out_valid_r;
    assign out_product      = out_product_r;
    assign count            = fifo_count_s;
    assign busy             = (state_r != IDLE) || !fifo_empty_s || out_valid_r;

endmodule
